// File: rtl/int_pe_sequencer.sv
// Command-driven sequencer for one integer MAC processing element: preloads the
// accumulator, streams operand pairs under valid/ready and returns the final sum.
module int_pe_sequencer #(
  parameter  int W_IN_A  = 8,
  parameter  int W_IN_B  = 16,
  parameter  int W_LEN   = 8,
  localparam int W_OUT_X = W_IN_A + W_IN_B
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               abort,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [W_LEN-1:0]   cmd_len,
  input  logic               cmd_bias_en,
  input  logic [W_OUT_X-1:0] cmd_bias,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [W_IN_A-1:0]  op_a,
  input  logic [W_IN_B-1:0]  op_b,
  output logic               pe_set_zero,
  output logic               pe_set,
  output logic [W_OUT_X-1:0] pe_set_value,
  output logic [W_IN_A-1:0]  pe_in_a,
  output logic [W_IN_B-1:0]  pe_in_b,
  input  logic [W_OUT_X-1:0] pe_out_x,
  input  logic               pe_overflow,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W_OUT_X-1:0] res_data,
  output logic               res_overflow,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [W_LEN-1:0]   len_q;
  logic [W_LEN-1:0]   cnt_q;
  logic [W_LEN-1:0]   cnt_inc;
  logic               bias_en_q;
  logic [W_OUT_X-1:0] bias_q;
  logic               ovf_q;
  logic               in_idle;
  logic               in_load;
  logic               in_accum;
  logic               in_done;
  logic               live_abort;
  logic               cmd_fire;
  logic               op_fire;

  assign in_idle  = (state == S_IDLE);
  assign in_load  = (state == S_LOAD);
  assign in_accum = (state == S_ACCUM);
  assign in_done  = (state == S_DONE);

  // Abort only has meaning once a command is in flight; in IDLE it just blocks acceptance.
  assign live_abort = abort && !in_idle;

  assign cmd_ready = in_idle && !abort;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign op_ready  = in_accum && !abort;
  assign op_fire   = op_valid && op_ready;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_nxt = state;
    if (live_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cmd_fire) state_nxt = S_LOAD;
        S_LOAD:  state_nxt = (len_q != '0) ? S_ACCUM : S_DONE;
        S_ACCUM: if (op_fire && (cnt_inc == len_q)) state_nxt = S_DONE;
        S_DONE:  if (res_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control state: FSM, command length, operand count, sticky overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      bias_en_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        len_q     <= cmd_len;
        bias_en_q <= cmd_bias_en;
        cnt_q     <= '0;
      end else if (op_fire) begin
        cnt_q <= cnt_inc;
      end
      if (in_load) begin
        ovf_q <= 1'b0;
      end else if (op_fire && pe_overflow) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Bias is datapath only; it is consumed solely in LOAD, after a command has latched it
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      bias_q <= cmd_bias;
    end
  end

  // PE drive: zero operands outside an accepted transfer so the accumulator holds
  assign pe_set       = in_load && bias_en_q && !abort;
  assign pe_set_zero  = (in_load && !bias_en_q) || live_abort;
  assign pe_set_value = in_load ? bias_q : '0;
  assign pe_in_a      = op_fire ? op_a : '0;
  assign pe_in_b      = op_fire ? op_b : '0;

  assign res_valid    = in_done && !abort;
  assign res_data     = in_done ? pe_out_x : '0;
  assign res_overflow = ovf_q;
  assign busy         = !in_idle;

endmodule

// File: tb/tb_int_pe_sequencer.sv
// Bench for int_pe_sequencer: behavioural PE, scoreboard of expected results,
// one task per scenario.
module tb_int_pe_sequencer;
  localparam int WA = 8;
  localparam int WB = 16;
  localparam int WX = 24;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          abort;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [WL-1:0] cmd_len;
  logic          cmd_bias_en;
  logic [WX-1:0] cmd_bias;
  logic          op_valid;
  logic          op_ready;
  logic [WA-1:0] op_a;
  logic [WB-1:0] op_b;
  logic          pe_set_zero;
  logic          pe_set;
  logic [WX-1:0] pe_set_value;
  logic [WA-1:0] pe_in_a;
  logic [WB-1:0] pe_in_b;
  logic [WX-1:0] pe_out_x;
  logic          pe_overflow;
  logic          res_valid;
  logic          res_ready;
  logic [WX-1:0] res_data;
  logic          res_overflow;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_cmd = 0;
  int n_push = 0;
  int n_res = 0;
  logic [WX-1:0] exp_data_q[$];
  logic          exp_ovf_q[$];

  int_pe_sequencer #(.W_IN_A(WA), .W_IN_B(WB), .W_LEN(WL)) dut (
    .clk(clk), .rstn(rstn), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_bias_en(cmd_bias_en), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_set_zero(pe_set_zero), .pe_set(pe_set), .pe_set_value(pe_set_value),
    .pe_in_a(pe_in_a), .pe_in_b(pe_in_b), .pe_out_x(pe_out_x), .pe_overflow(pe_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PE: accumulator with set/clear, combinational carry-out
  logic [WX-1:0] pe_acc;
  logic [WX:0]   pe_sum;
  assign pe_sum      = {1'b0, pe_acc} + {1'b0, WX'(pe_in_a) * WX'(pe_in_b)};
  assign pe_out_x    = pe_acc;
  assign pe_overflow = pe_sum[WX];
  always @(posedge clk or negedge rstn) begin
    if (!rstn)            pe_acc <= '0;
    else if (pe_set_zero) pe_acc <= '0;
    else if (pe_set)      pe_acc <= pe_set_value;
    else                  pe_acc <= pe_sum[WX-1:0];
  end

  // Result monitor: every consumed result is popped and compared
  always @(negedge clk) begin
    if (rstn && res_valid && res_ready) begin
      checks++;
      n_res++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%0h ovf=%b, required no result", res_data, res_overflow);
      end else begin
        logic [WX-1:0] ed;
        logic          eo;
        ed = exp_data_q.pop_front();
        eo = exp_ovf_q.pop_front();
        if (res_data !== ed || res_overflow !== eo) begin
          errors++;
          $display("FAIL result: got data=%0h ovf=%b, required data=%0h ovf=%b", res_data, res_overflow, ed, eo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic push_expect(input int len, input logic ben, input logic [WX-1:0] bias,
                             input logic [WA-1:0] av[4], input logic [WB-1:0] bv[4]);
    longint acc;
    logic   ov;
    acc = ben ? longint'(bias) : 0;
    ov  = 1'b0;
    for (int i = 0; i < len; i++) begin
      acc = acc + longint'(av[i]) * longint'(bv[i]);
      if (acc >= 64'd16777216) begin
        ov  = 1'b1;
        acc = acc - 64'd16777216;
      end
    end
    exp_data_q.push_back(WX'(acc));
    exp_ovf_q.push_back(ov);
    n_push++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [WL-1:0] len, input logic ben, input logic [WX-1:0] bias);
    int n = 0;
    cmd_valid = 1'b1; cmd_len = len; cmd_bias_en = ben; cmd_bias = bias;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 20 cycles", cmd_ready);
    end
    t_cmd = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [WA-1:0] a, input logic [WB-1:0] b);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_accept: op_ready=%b, required 1 within 20 cycles", op_ready);
    end
    step();
    op_valid = 1'b0; op_a = '0; op_b = '0;
  endtask

  task automatic wait_res();
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL res_wait: res_valid=%b, required 1 within 40 cycles", res_valid);
    end
  endtask

  task automatic test_reset();
    step();
    @(negedge clk);
    checks++;
    if ({cmd_ready, op_ready, res_valid, busy, pe_set, pe_set_zero, res_overflow} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got {cmd_rdy,op_rdy,res_vld,busy,set,set0,ovf}=%b, required 1000000",
               {cmd_ready, op_ready, res_valid, busy, pe_set, pe_set_zero, res_overflow});
    end
    checks++;
    if (pe_in_a !== '0 || pe_in_b !== '0) begin
      errors++;
      $display("FAIL reset_pe_in: got a=%0h b=%0h, required 0 0", pe_in_a, pe_in_b);
    end
    step();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    step();
    res_ready = 1'b1;
    send_cmd(3, 1'b0, 0);
    push_expect(3, 1'b0, 0, '{8'd2, 8'd3, 8'd4, 8'd0}, '{16'd10, 16'd20, 16'd30, 16'd0});
    send_op(2, 10);
    send_op(3, 20);
    send_op(4, 30);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || (cyc - t_cmd) != 5) begin
      errors++;
      $display("FAIL basic_latency: got res_valid=%b at T+%0d, required 1 at T+5", res_valid, cyc - t_cmd);
    end
    step();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: got res_valid=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    step();
    res_ready = 1'b0;
    send_cmd(2, 1'b1, 1000);
    push_expect(2, 1'b1, 1000, '{8'd5, 8'd1, 8'd0, 8'd0}, '{16'd7, 16'd1, 16'd0, 16'd0});
    send_op(5, 7);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1 || pe_in_a !== '0) begin
        errors++;
        $display("FAIL gap_op_ready: got op_ready=%b pe_in_a=%0h, required 1 0", op_ready, pe_in_a);
      end
      step();
    end
    send_op(1, 1);
    wait_res();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin step(); @(negedge clk); end
      checks++;
      if (res_valid !== 1'b1 || res_data !== 24'd1036) begin
        errors++;
        $display("FAIL hold_result: got res_valid=%b data=%0d, required 1 1036", res_valid, res_data);
      end
    end
    step();
    res_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_overflow();
    step();
    send_cmd(1, 1'b1, 24'hFFFFF0);
    push_expect(1, 1'b1, 24'hFFFFF0, '{8'd1, 8'd0, 8'd0, 8'd0}, '{16'h20, 16'd0, 16'd0, 16'd0});
    send_op(1, 16'h20);
    wait_res();
    checks++;
    if (res_data !== 24'h000010 || res_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got data=%0h ovf=%b, required 10 1", res_data, res_overflow);
    end
    step();
    send_cmd(1, 1'b1, 0);
    push_expect(1, 1'b1, 0, '{8'd1, 8'd0, 8'd0, 8'd0}, '{16'd1, 16'd0, 16'd0, 16'd0});
    send_op(1, 1);
    wait_res();
    checks++;
    if (res_data !== 24'd1 || res_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got data=%0h ovf=%b, required 1 0", res_data, res_overflow);
    end
  endtask

  task automatic test_len_zero();
    step();
    send_cmd(0, 1'b1, 42);
    push_expect(0, 1'b1, 42, '{8'd0, 8'd0, 8'd0, 8'd0}, '{16'd0, 16'd0, 16'd0, 16'd0});
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b0 || res_valid !== 1'b0 || pe_set !== 1'b1 || pe_set_value !== 24'd42) begin
      errors++;
      $display("FAIL len0_load: got op_ready=%b res_valid=%b set=%b val=%0d, required 0 0 1 42",
               op_ready, res_valid, pe_set, pe_set_value);
    end
    step();
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || (cyc - t_cmd) != 2 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL len0_latency: got res_valid=%b op_ready=%b at T+%0d, required 1 0 at T+2",
               res_valid, op_ready, cyc - t_cmd);
    end
    step();
    send_cmd(0, 1'b0, 24'd99);
    push_expect(0, 1'b0, 24'd99, '{8'd0, 8'd0, 8'd0, 8'd0}, '{16'd0, 16'd0, 16'd0, 16'd0});
    wait_res();
    step();
  endtask

  task automatic test_abort();
    step();
    send_cmd(4, 1'b0, 0);
    send_op(1, 1);
    abort = 1'b1; op_valid = 1'b1; op_a = 8'd2; op_b = 16'd2;
    @(negedge clk);
    checks++;
    if (pe_set_zero !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || pe_in_a !== '0) begin
      errors++;
      $display("FAIL abort_cycle: got set0=%b op_ready=%b res_valid=%b pe_in_a=%0h, required 1 0 0 0",
               pe_set_zero, op_ready, res_valid, pe_in_a);
    end
    step();
    abort = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b cmd_ready=%b, required 0 1", busy, cmd_ready);
    end
    step();
    abort = 1'b1; cmd_valid = 1'b1; cmd_len = 8'd1; cmd_bias_en = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || pe_set_zero !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: got cmd_ready=%b set0=%b, required 0 0", cmd_ready, pe_set_zero);
    end
    step();
    abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_accept: got busy=%b, required 0", busy);
    end
    step();
    send_cmd(1, 1'b0, 0);
    push_expect(1, 1'b0, 0, '{8'd3, 8'd0, 8'd0, 8'd0}, '{16'd3, 16'd0, 16'd0, 16'd0});
    send_op(3, 3);
    wait_res();
    step();
  endtask

  task automatic test_reset_mid();
    step();
    send_cmd(3, 1'b1, 24'hFFFFFF);
    send_op(1, 1);
    @(negedge clk);
    checks++;
    if (res_overflow !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_precond: got ovf=%b busy=%b, required 1 1", res_overflow, busy);
    end
    step();
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_overflow !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b res_valid=%b ovf=%b cmd_ready=%b, required 0 0 0 1",
               busy, res_valid, res_overflow, cmd_ready);
    end
    step();
    step();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_overflow !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_release: got busy=%b res_valid=%b ovf=%b cmd_ready=%b, required 0 0 0 1",
               busy, res_valid, res_overflow, cmd_ready);
    end
    step();
    send_cmd(3, 1'b0, 0);
    push_expect(3, 1'b0, 0, '{8'd2, 8'd3, 8'd4, 8'd0}, '{16'd10, 16'd20, 16'd30, 16'd0});
    send_op(2, 10);
    send_op(3, 20);
    send_op(4, 30);
    wait_res();
    checks++;
    if (res_data !== 24'd200) begin
      errors++;
      $display("FAIL rerun_data: got %0d, required 200", res_data);
    end
    step();
  endtask

  initial begin
    rstn = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_bias_en = 1'b0;
    cmd_bias = '0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    #2 rstn = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_len_zero();
    test_abort();
    test_reset_mid();
    step();
    step();
    checks++;
    if (exp_data_q.size() != 0 || n_res != n_push) begin
      errors++;
      $display("FAIL drain: got %0d results with %0d pending, required %0d results with 0 pending",
               n_res, exp_data_q.size(), n_push);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
